// File: rtl/hilo_md_ctrl.sv
// HI/LO register file with DIV/DIVU sequencing onto external 32-cycle dividers.
// Define MULT_EN to compile in the internal 32-cycle shift-add multiplier for MULT/MULTU.
module hilo_md_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        stall,
  output logic        md_done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  output logic        div_start,
  input  logic        div_busy,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r,
  output logic [31:0] divu_dividend,
  output logic [31:0] divu_divisor,
  output logic        divu_start,
  input  logic        divu_busy,
  input  logic [31:0] divu_q,
  input  logic [31:0] divu_r
);

  localparam logic [2:0] OP_DIV   = 3'b001;
  localparam logic [2:0] OP_DIVU  = 3'b010;
  localparam logic [2:0] OP_MULT  = 3'b011;
  localparam logic [2:0] OP_MULTU = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [2:0] {IDLE, DIV_ISSUE, DIV_WAIT, MUL_RUN, DONE} state_t;

  state_t state, next_state;
  logic   sel_unsigned;
  logic   seen_busy;
  logic   op_is_div;
  logic   op_is_mul;
  logic   sel_busy;

  assign op_is_div = (op_code == OP_DIV) || (op_code == OP_DIVU);
  assign sel_busy  = sel_unsigned ? divu_busy : div_busy;

`ifdef MULT_EN
  logic [63:0] acc;
  logic [63:0] mul_a;
  logic [31:0] mul_b;
  logic        mul_neg;
  logic [5:0]  mul_count;
  logic [63:0] acc_next;
  logic [63:0] product;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic        mul_signed;
  logic        mul_last;

  assign op_is_mul  = (op_code == OP_MULT) || (op_code == OP_MULTU);
  assign mul_signed = (op_code == OP_MULT);
  assign mag_a      = (mul_signed && rs_val[31]) ? (~rs_val + 32'd1) : rs_val;
  assign mag_b      = (mul_signed && rt_val[31]) ? (~rt_val + 32'd1) : rt_val;
  assign acc_next   = acc + (mul_b[0] ? mul_a : 64'd0);
  assign product    = mul_neg ? (~acc_next + 64'd1) : acc_next;
  assign mul_last   = (mul_count == 6'd31);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc       <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      mul_neg   <= 1'b0;
      mul_count <= '0;
    end else if (state == IDLE && op_valid && op_is_mul) begin
      acc       <= '0;
      mul_a     <= {32'd0, mag_a};
      mul_b     <= mag_b;
      mul_neg   <= mul_signed && (rs_val[31] ^ rt_val[31]);
      mul_count <= '0;
    end else if (state == MUL_RUN) begin
      acc       <= acc_next;
      mul_a     <= mul_a << 1;
      mul_b     <= mul_b >> 1;
      mul_count <= mul_count + 6'd1;
    end
  end
`else
  assign op_is_mul = 1'b0;
`endif

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    next_state = state;
    stall      = 1'b0;
    md_done    = 1'b0;
    div_start  = 1'b0;
    divu_start = 1'b0;
    case (state)
      IDLE: begin
        if (op_valid && op_is_div) begin
          stall      = 1'b1;
          next_state = (rt_val == 32'd0) ? DONE : DIV_ISSUE;
        end else if (op_valid && op_is_mul) begin
          stall      = 1'b1;
          next_state = MUL_RUN;
        end
      end
      DIV_ISSUE: begin
        stall      = 1'b1;
        div_start  = ~sel_unsigned;
        divu_start = sel_unsigned;
        next_state = DIV_WAIT;
      end
      DIV_WAIT: begin
        stall = 1'b1;
        if (!sel_busy && seen_busy) next_state = DONE;
      end
      MUL_RUN: begin
`ifdef MULT_EN
        stall = 1'b1;
        if (mul_last) next_state = DONE;
`else
        next_state = IDLE;
`endif
      end
      DONE: begin
        md_done    = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Busy only counts as finished once it has been seen high after the start pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hi            <= '0;
      lo            <= '0;
      div_dividend  <= '0;
      div_divisor   <= '0;
      divu_dividend <= '0;
      divu_divisor  <= '0;
      sel_unsigned  <= 1'b0;
      seen_busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (op_valid) begin
            case (op_code)
              OP_DIV: if (rt_val != 32'd0) begin
                div_dividend <= rs_val;
                div_divisor  <= rt_val;
                sel_unsigned <= 1'b0;
              end
              OP_DIVU: if (rt_val != 32'd0) begin
                divu_dividend <= rs_val;
                divu_divisor  <= rt_val;
                sel_unsigned  <= 1'b1;
              end
              OP_MTHI: hi <= rs_val;
              OP_MTLO: lo <= rs_val;
              default: ;
            endcase
          end
        end
        DIV_ISSUE: seen_busy <= 1'b0;
        DIV_WAIT: begin
          if (sel_busy) begin
            seen_busy <= 1'b1;
          end else if (seen_busy) begin
            lo <= sel_unsigned ? divu_q : div_q;
            hi <= sel_unsigned ? divu_r : div_r;
          end
        end
`ifdef MULT_EN
        MUL_RUN: if (mul_last) {hi, lo} <= product;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_md_ctrl.sv
// Directed bench for hilo_md_ctrl with behavioural 32-cycle divider models.
// Build with +define+MULT_EN to exercise the multiplier path instead of its no-op behaviour.
module tb_hilo_md_ctrl;

  localparam logic [2:0] OP_DIV   = 3'b001;
  localparam logic [2:0] OP_DIVU  = 3'b010;
  localparam logic [2:0] OP_MULT  = 3'b011;
  localparam logic [2:0] OP_MULTU = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  logic        clock = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [31:0] rs_val, rt_val;
  logic        stall, md_done;
  logic [31:0] hi, lo;
  logic [31:0] div_dividend, div_divisor, div_q, div_r;
  logic        div_start, div_busy;
  logic [31:0] divu_dividend, divu_divisor, divu_q, divu_r;
  logic        divu_start, divu_busy;

  int passed = 0;
  int total  = 0;

  // results of the last run_op
  int          r_stall, r_done, r_ds, r_ds_c, r_dus, r_dus_c;
  logic        r_idle;
  logic [31:0] r_hi, r_lo;

  always #5 clock = ~clock;

  hilo_md_ctrl dut (
    .clock(clock), .reset(reset), .op_valid(op_valid), .op_code(op_code),
    .rs_val(rs_val), .rt_val(rt_val), .stall(stall), .md_done(md_done),
    .hi(hi), .lo(lo),
    .div_dividend(div_dividend), .div_divisor(div_divisor), .div_start(div_start),
    .div_busy(div_busy), .div_q(div_q), .div_r(div_r),
    .divu_dividend(divu_dividend), .divu_divisor(divu_divisor), .divu_start(divu_start),
    .divu_busy(divu_busy), .divu_q(divu_q), .divu_r(divu_r)
  );

  // Divider models: busy rises the edge after start, stays 32 cycles, q/r valid as busy falls.
  int          div_cnt, divu_cnt;
  logic [31:0] div_hq, div_hr, divu_hq, divu_hr;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      div_busy <= 1'b0; div_cnt <= 0; div_q <= '0; div_r <= '0; div_hq <= '0; div_hr <= '0;
    end else if (!div_busy && div_start) begin
      div_busy <= 1'b1; div_cnt <= 31;
      div_hq   <= $signed(div_dividend) / $signed(div_divisor);
      div_hr   <= $signed(div_dividend) % $signed(div_divisor);
      div_q    <= 32'hDEADBEEF; div_r <= 32'hDEADBEEF;
    end else if (div_busy) begin
      if (div_cnt == 0) begin
        div_busy <= 1'b0; div_q <= div_hq; div_r <= div_hr;
      end else div_cnt <= div_cnt - 1;
    end
  end

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      divu_busy <= 1'b0; divu_cnt <= 0; divu_q <= '0; divu_r <= '0; divu_hq <= '0; divu_hr <= '0;
    end else if (!divu_busy && divu_start) begin
      divu_busy <= 1'b1; divu_cnt <= 31;
      divu_hq   <= divu_dividend / divu_divisor;
      divu_hr   <= divu_dividend % divu_divisor;
      divu_q    <= 32'hDEADBEEF; divu_r <= 32'hDEADBEEF;
    end else if (divu_busy) begin
      if (divu_cnt == 0) begin
        divu_busy <= 1'b0; divu_q <= divu_hq; divu_r <= divu_hr;
      end else divu_cnt <= divu_cnt - 1;
    end
  end

  // Called between a negedge and the following posedge; the op is offered in that cycle (cycle 0).
  task automatic run_op(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b);
    r_stall = 0; r_done = -1; r_ds = 0; r_ds_c = -1; r_dus = 0; r_dus_c = -1;
    r_hi = 'x; r_lo = 'x;
    op_valid = 1'b1; op_code = code; rs_val = a; rt_val = b;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (stall) r_stall++;
      if (div_start) begin r_ds++; r_ds_c = c; end
      if (divu_start) begin r_dus++; r_dus_c = c; end
      if (md_done) begin r_done = c; r_hi = hi; r_lo = lo; break; end
      @(negedge clock);
    end
    @(negedge clock);
    op_valid = 1'b0;
    #1 r_idle = !stall && !md_done && !div_start && !divu_start;
  endtask

  task automatic test_reset();
    reset = 1'b0; op_valid = 1'b0; op_code = '0; rs_val = '0; rt_val = '0;
    #2 reset = 1'b1;
    #3;
    total++; if (hi !== 32'd0) $display("FAIL reset_hi: got %h want 0", hi); else passed++;
    total++; if (lo !== 32'd0) $display("FAIL reset_lo: got %h want 0", lo); else passed++;
    total++; if (stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall); else passed++;
    total++; if (md_done !== 1'b0) $display("FAIL reset_md_done: got %b want 0", md_done); else passed++;
    total++; if ({div_start, divu_start} !== 2'b00) $display("FAIL reset_start: got %b want 00", {div_start, divu_start}); else passed++;
    total++; if (div_dividend !== 32'd0) $display("FAIL reset_dividend: got %h want 0", div_dividend); else passed++;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_div();
    @(negedge clock);
    run_op(OP_DIV, 32'hFFFFFFF9, 32'd2);
    total++; if (r_lo !== 32'hFFFFFFFD) $display("FAIL div_lo: got %h want fffffffd", r_lo); else passed++;
    total++; if (r_hi !== 32'hFFFFFFFF) $display("FAIL div_hi: got %h want ffffffff", r_hi); else passed++;
    total++; if (r_stall != 35) $display("FAIL div_stall_cycles: got %0d want 35", r_stall); else passed++;
    total++; if (r_done != 35) $display("FAIL div_done_cycle: got %0d want 35", r_done); else passed++;
    total++; if (r_ds != 1 || r_ds_c != 1) $display("FAIL div_start_pulse: got count %0d cycle %0d want 1/1", r_ds, r_ds_c); else passed++;
    total++; if (r_dus != 0) $display("FAIL div_divu_start: got %0d want 0", r_dus); else passed++;
    total++; if (r_idle !== 1'b1) $display("FAIL div_idle_after_done: got %b want 1", r_idle); else passed++;
  endtask

  task automatic test_divu();
    @(negedge clock);
    run_op(OP_DIVU, 32'hFFFFFFFF, 32'd16);
    total++; if (r_lo !== 32'h0FFFFFFF) $display("FAIL divu_lo: got %h want 0fffffff", r_lo); else passed++;
    total++; if (r_hi !== 32'h0000000F) $display("FAIL divu_hi: got %h want 0000000f", r_hi); else passed++;
    total++; if (r_stall != 35) $display("FAIL divu_stall_cycles: got %0d want 35", r_stall); else passed++;
    total++; if (r_dus != 1 || r_dus_c != 1) $display("FAIL divu_start_pulse: got count %0d cycle %0d want 1/1", r_dus, r_dus_c); else passed++;
    total++; if (r_ds != 0) $display("FAIL divu_div_start: got %0d want 0", r_ds); else passed++;
  endtask

`ifdef MULT_EN
  task automatic test_mult();
    @(negedge clock);
    run_op(OP_MULT, 32'hFFFFFFFD, 32'd5);
    total++; if (r_hi !== 32'hFFFFFFFF) $display("FAIL mult_hi: got %h want ffffffff", r_hi); else passed++;
    total++; if (r_lo !== 32'hFFFFFFF1) $display("FAIL mult_lo: got %h want fffffff1", r_lo); else passed++;
    total++; if (r_stall != 33 || r_done != 33) $display("FAIL mult_timing: got stall %0d done %0d want 33/33", r_stall, r_done); else passed++;
    total++; if (r_ds != 0 || r_dus != 0) $display("FAIL mult_no_div_start: got %0d/%0d want 0/0", r_ds, r_dus); else passed++;
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    total++; if (r_hi !== 32'hFFFFFFFE) $display("FAIL multu_hi: got %h want fffffffe", r_hi); else passed++;
    total++; if (r_lo !== 32'h00000001) $display("FAIL multu_lo: got %h want 00000001", r_lo); else passed++;
    total++; if (r_stall != 33 || r_done != 33) $display("FAIL multu_timing: got stall %0d done %0d want 33/33", r_stall, r_done); else passed++;
  endtask
`else
  task automatic test_mult_disabled();
    logic any_stall, any_done;
    any_stall = 1'b0; any_done = 1'b0;
    @(negedge clock);
    op_valid = 1'b1; op_code = OP_MULT; rs_val = 32'd7; rt_val = 32'd7;
    for (int c = 0; c < 4; c++) begin
      #1;
      any_stall |= stall;
      any_done  |= md_done;
      @(negedge clock);
    end
    op_valid = 1'b0;
    #1;
    total++; if (any_stall !== 1'b0) $display("FAIL mult_off_stall: got %b want 0", any_stall); else passed++;
    total++; if (any_done !== 1'b0) $display("FAIL mult_off_md_done: got %b want 0", any_done); else passed++;
    total++; if (hi !== 32'h0000000F) $display("FAIL mult_off_hi: got %h want 0000000f", hi); else passed++;
    total++; if (lo !== 32'h0FFFFFFF) $display("FAIL mult_off_lo: got %h want 0fffffff", lo); else passed++;
  endtask
`endif

  task automatic test_mthi_mtlo_div0();
    logic [31:0] hi_exp, lo_exp;
    hi_exp = 32'h12345678; lo_exp = 32'h9ABCDEF0;
    @(negedge clock);
    op_valid = 1'b1; op_code = OP_MTHI; rs_val = hi_exp; rt_val = '0;
    #1;
    total++; if (stall !== 1'b0) $display("FAIL mthi_stall: got %b want 0", stall); else passed++;
    @(negedge clock);
    total++; if (hi !== hi_exp) $display("FAIL mthi_value: got %h want %h", hi, hi_exp); else passed++;
    op_code = OP_MTLO; rs_val = lo_exp;
    #1;
    total++; if (stall !== 1'b0) $display("FAIL mtlo_stall: got %b want 0", stall); else passed++;
    @(negedge clock);
    op_valid = 1'b0;
    total++; if (lo !== lo_exp) $display("FAIL mtlo_value: got %h want %h", lo, lo_exp); else passed++;
    total++; if (hi !== hi_exp) $display("FAIL mtlo_keeps_hi: got %h want %h", hi, hi_exp); else passed++;
    run_op(OP_DIV, 32'd5, 32'd0);
    total++; if (r_stall != 1 || r_done != 1) $display("FAIL div0_timing: got stall %0d done %0d want 1/1", r_stall, r_done); else passed++;
    total++; if (r_ds != 0 || r_dus != 0) $display("FAIL div0_start: got %0d/%0d want 0/0", r_ds, r_dus); else passed++;
    total++; if (r_hi !== hi_exp || r_lo !== lo_exp) $display("FAIL div0_hilo: got %h/%h want %h/%h", r_hi, r_lo, hi_exp, lo_exp); else passed++;
    total++; if (r_idle !== 1'b1) $display("FAIL div0_idle_after_done: got %b want 1", r_idle); else passed++;
  endtask

  task automatic test_reset_mid_div();
    @(negedge clock);
    op_valid = 1'b1; op_code = OP_DIV; rs_val = 32'd100; rt_val = 32'd7;
    repeat (10) @(negedge clock);
    #1 reset = 1'b1; op_valid = 1'b0;
    #1;
    total++; if (hi !== 32'd0 || lo !== 32'd0) $display("FAIL midreset_hilo: got %h/%h want 0/0", hi, lo); else passed++;
    total++; if (stall !== 1'b0 || md_done !== 1'b0) $display("FAIL midreset_stall: got %b/%b want 0/0", stall, md_done); else passed++;
    total++; if (div_dividend !== 32'd0 || div_divisor !== 32'd0) $display("FAIL midreset_operands: got %h/%h want 0/0", div_dividend, div_divisor); else passed++;
    @(negedge clock);
    reset = 1'b0;
    #1;
    total++; if (stall !== 1'b0 || div_start !== 1'b0) $display("FAIL midreset_idle: got stall %b start %b want 0/0", stall, div_start); else passed++;
    @(negedge clock);
    run_op(OP_DIV, 32'd100, 32'd7);
    total++; if (r_lo !== 32'd14 || r_hi !== 32'd2) $display("FAIL postreset_div: got lo %h hi %h want 0000000e/00000002", r_lo, r_hi); else passed++;
    total++; if (r_stall != 35 || r_done != 35) $display("FAIL postreset_timing: got stall %0d done %0d want 35/35", r_stall, r_done); else passed++;
  endtask

  task automatic test_back_to_back();
    @(negedge clock);
    run_op(OP_DIVU, 32'd100, 32'd3);
    total++; if (r_lo !== 32'd33 || r_hi !== 32'd1) $display("FAIL b2b_divu: got lo %h hi %h want 00000021/00000001", r_lo, r_hi); else passed++;
    run_op(OP_DIV, 32'hFFFFFF9C, 32'd3);
    total++; if (r_lo !== 32'hFFFFFFDF || r_hi !== 32'hFFFFFFFF) $display("FAIL b2b_div: got lo %h hi %h want ffffffdf/ffffffff", r_lo, r_hi); else passed++;
    total++; if (r_stall != 35 || r_done != 35) $display("FAIL b2b_timing: got stall %0d done %0d want 35/35", r_stall, r_done); else passed++;
    total++; if (r_ds != 1 || r_dus != 0) $display("FAIL b2b_start: got %0d/%0d want 1/0", r_ds, r_dus); else passed++;
  endtask

  initial begin
    test_reset();
    test_div();
    test_divu();
`ifdef MULT_EN
    test_mult();
`else
    test_mult_disabled();
`endif
    test_mthi_mtlo_div0();
    test_reset_mid_div();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
